pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter FETCH_TIMEOUT, default 8, which is the maximum number of FETCH cycles spent waiting for MemReady (range 1..255).
REQ-002 SHALL have port Clock, input, 1 bit: clock; all state changes on its rising edge.
REQ-003 SHALL have port Reset, input, 1 bit: reset, asynchronous, active-high.
REQ-004 SHALL have port Start, input, 1 bit: begin execution from IDLE.
REQ-005 SHALL have ports MemRead (output, 1 bit: instruction read request), MemReady (input, 1 bit: read data valid) and Instr (input, 16 bits: instruction data).
REQ-006 SHALL have port ZeroFlag, input, 1 bit: datapath zero flag used by conditional branches.
REQ-007 SHALL have ports AluStart (output, 1 bit: ALU operation pulse) and AluDone (input, 1 bit: ALU completion).
REQ-008 SHALL have PC control outputs: PcStep (1 bit), PcLoad (1 bit), PcLoadValue (16 bits), PcOffsetEnable (1 bit), PcOffset (9 bits).
REQ-009 SHALL have status outputs: IrOut (16 bits: instruction register), Busy (1 bit), Halted (1 bit), Error (1 bit), InstrCount (16 bits).

Function
REQ-010 SHALL implement states IDLE, FETCH, DECODE, WAIT_ALU, HALT and ERROR.
REQ-011 SHALL move IDLE -> FETCH when Start=1; Start SHALL be ignored in every other state.
REQ-012 SHALL drive MemRead=1 in FETCH only.
REQ-013 In FETCH with MemReady=1, SHALL capture Instr into IrOut on that edge and move to DECODE (fetch-to-decode latency of 1 cycle).
REQ-014 SHALL use a timeout counter that clears on FETCH entry and increments on each FETCH cycle with MemReady=0.
REQ-015 When the timeout counter reaches FETCH_TIMEOUT, SHALL move to ERROR; MemReady=1 in that same cycle SHALL take priority, so the instruction is captured and the machine moves to DECODE.
REQ-016 SHALL decode IrOut[15:12] in DECODE; every PC control output SHALL be a single-cycle pulse asserted in DECODE or WAIT_ALU only.
REQ-017 Opcode 4'h0 (NOP): SHALL assert PcStep and move to FETCH.
REQ-018 Opcode 4'hC (JMP): SHALL assert PcLoad with PcLoadValue={4'h0,IrOut[11:0]} and move to FETCH.
REQ-019 Opcode 4'hD (BZ) with ZeroFlag=1: SHALL assert PcOffsetEnable with PcOffset=IrOut[8:0] (unsigned, 16-bit wrap in the PC) and move to FETCH.
REQ-020 Opcode 4'hD (BZ) with ZeroFlag=0: SHALL assert PcStep and move to FETCH.
REQ-021 Opcode 4'hF (HALT): SHALL assert no PC control and move to HALT.
REQ-022 Any other opcode (ALU): SHALL pulse AluStart and move to WAIT_ALU.
REQ-023 In WAIT_ALU, SHALL sample AluDone; when AluDone=1, SHALL assert PcStep and move to FETCH. AluDone SHALL be ignored in every other state.
REQ-024 SHALL never assert more than one of PcStep, PcLoad and PcOffsetEnable in the same cycle.
REQ-025 SHALL drive PcLoadValue and PcOffset to 0 whenever PcLoad or PcOffsetEnable, respectively, is 0.
REQ-026 HALT and ERROR SHALL be terminal; only Reset exits them.
REQ-027 SHALL assert Halted=1 in HALT and Error=1 in ERROR.
REQ-028 SHALL assert Busy=1 in FETCH, DECODE and WAIT_ALU.
REQ-029 All outputs SHALL be combinational decodes of the registered state and IrOut; none SHALL depend on Start.

Reset
REQ-030 Reset SHALL force IDLE, IrOut=0, timeout counter=0 and InstrCount=0 asynchronously, including in the middle of a fetch or an ALU wait.
REQ-031 While Reset=1, every output SHALL be 0.
REQ-032 After Reset deasserts, the first state change SHALL require Start=1.

Configuration
REQ-033 With macro PC_SEQUENCER_INSTR_COUNT_EN defined, InstrCount SHALL increment by 1 on each DECODE exit (HALT included) and wrap from 16'hFFFF to 0.
REQ-034 Without PC_SEQUENCER_INSTR_COUNT_EN, InstrCount SHALL be tied to 0 and no counter register SHALL be built.

Verification
REQ-035 Reset, Start pulse, MemReady=1 with Instr=16'h0000 -> MemRead for 1 cycle, IrOut=0000, PcStep pulse in DECODE, back to FETCH.
REQ-036 Instr=16'hC123 -> PcLoad=1 with PcLoadValue=16'h0123 for exactly 1 cycle; PcStep=0 throughout.
REQ-037 Instr=16'hD005 with ZeroFlag=1 -> PcOffsetEnable=1 with PcOffset=9'h005; the same instruction with ZeroFlag=0 -> PcStep=1.
REQ-038 Instr=16'h3000, AluDone held 0 for 5 cycles then 1 -> AluStart pulses once, Busy stays 1, PcStep fires on the AluDone cycle.
REQ-039 FETCH_TIMEOUT=8 with MemReady held 0 -> Error=1 after 8 FETCH cycles; MemReady=1 on cycle 8 instead -> DECODE, Error=0.
REQ-040 Instr=16'hF000, then Start pulsed -> Halted=1 and stays 1; Reset asserted mid-WAIT_ALU -> all outputs 0 and IDLE; with PC_SEQUENCER_INSTR_COUNT_EN defined, 3 decoded instructions -> InstrCount=3.

Source files
------------

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - instruction fetch/decode sequencer driving PC control and ALU handshakes
// Optional instruction counter enabled by defining PC_SEQUENCER_INSTR_COUNT_EN.
module pc_sequencer #(
  parameter int unsigned FETCH_TIMEOUT = 8
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Start,
  output logic        MemRead,
  input  logic        MemReady,
  input  logic [15:0] Instr,
  input  logic        ZeroFlag,
  output logic        AluStart,
  input  logic        AluDone,
  output logic        PcStep,
  output logic        PcLoad,
  output logic [15:0] PcLoadValue,
  output logic        PcOffsetEnable,
  output logic [8:0]  PcOffset,
  output logic [15:0] IrOut,
  output logic        Busy,
  output logic        Halted,
  output logic        Error,
  output logic [15:0] InstrCount
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_WAIT_ALU,
    S_HALT,
    S_ERROR
  } state_t;

  localparam logic [7:0] TIMEOUT_LAST = 8'(FETCH_TIMEOUT - 1);

  state_t      r_state;
  state_t      w_next;
  logic [7:0]  r_timeout;
  logic [15:0] r_ir;
  logic [3:0]  w_opcode;

  assign w_opcode = r_ir[15:12];
  assign IrOut    = r_ir;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Counter only advances while stalled in FETCH, so it is zero on every FETCH entry.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_timeout <= 8'd0;
      r_ir      <= 16'd0;
    end else begin
      if (r_state == S_FETCH && !MemReady) begin
        r_timeout <= r_timeout + 8'd1;
      end else begin
        r_timeout <= 8'd0;
      end
      if (r_state == S_FETCH && MemReady) begin
        r_ir <= Instr;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (Start) w_next = S_FETCH;
      end
      S_FETCH: begin
        if (MemReady) begin
          w_next = S_DECODE;
        end else if (r_timeout == TIMEOUT_LAST) begin
          w_next = S_ERROR;
        end
      end
      S_DECODE: begin
        case (w_opcode)
          4'h0, 4'hC, 4'hD: w_next = S_FETCH;
          4'hF:             w_next = S_HALT;
          default:          w_next = S_WAIT_ALU;
        endcase
      end
      S_WAIT_ALU: begin
        if (AluDone) w_next = S_FETCH;
      end
      default: w_next = r_state;
    endcase
  end

  always_comb begin
    MemRead        = 1'b0;
    AluStart       = 1'b0;
    PcStep         = 1'b0;
    PcLoad         = 1'b0;
    PcLoadValue    = 16'd0;
    PcOffsetEnable = 1'b0;
    PcOffset       = 9'd0;
    Busy           = 1'b0;
    Halted         = 1'b0;
    Error          = 1'b0;
    case (r_state)
      S_FETCH: begin
        MemRead = 1'b1;
        Busy    = 1'b1;
      end
      S_DECODE: begin
        Busy = 1'b1;
        case (w_opcode)
          4'h0: PcStep = 1'b1;
          4'hC: begin
            PcLoad      = 1'b1;
            PcLoadValue = {4'h0, r_ir[11:0]};
          end
          4'hD: begin
            if (ZeroFlag) begin
              PcOffsetEnable = 1'b1;
              PcOffset       = r_ir[8:0];
            end else begin
              PcStep = 1'b1;
            end
          end
          4'hF: ;
          default: AluStart = 1'b1;
        endcase
      end
      S_WAIT_ALU: begin
        Busy   = 1'b1;
        PcStep = AluDone;
      end
      S_HALT:  Halted = 1'b1;
      S_ERROR: Error  = 1'b1;
      default: ;
    endcase
  end

`ifdef PC_SEQUENCER_INSTR_COUNT_EN
  logic [15:0] r_instr_count;

  // DECODE always lasts one cycle, so every DECODE cycle is one retired instruction.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_instr_count <= 16'd0;
    end else if (r_state == S_DECODE) begin
      r_instr_count <= r_instr_count + 16'd1;
    end
  end

  assign InstrCount = r_instr_count;
`else
  assign InstrCount = 16'd0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed self-checking bench for pc_sequencer
module tb_pc_sequencer;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        Start;
  logic        MemRead;
  logic        MemReady;
  logic [15:0] Instr;
  logic        ZeroFlag;
  logic        AluStart;
  logic        AluDone;
  logic        PcStep;
  logic        PcLoad;
  logic [15:0] PcLoadValue;
  logic        PcOffsetEnable;
  logic [8:0]  PcOffset;
  logic [15:0] IrOut;
  logic        Busy;
  logic        Halted;
  logic        Error;
  logic [15:0] InstrCount;

  pc_sequencer #(.FETCH_TIMEOUT(8)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start),
    .MemRead(MemRead), .MemReady(MemReady), .Instr(Instr),
    .ZeroFlag(ZeroFlag), .AluStart(AluStart), .AluDone(AluDone),
    .PcStep(PcStep), .PcLoad(PcLoad), .PcLoadValue(PcLoadValue),
    .PcOffsetEnable(PcOffsetEnable), .PcOffset(PcOffset),
    .IrOut(IrOut), .Busy(Busy), .Halted(Halted), .Error(Error),
    .InstrCount(InstrCount)
  );

  always #5 Clock = ~Clock;

  // kind: 0 step, 1 load, 2 offset, 3 halt, 7 nothing seen
  typedef struct {
    logic [2:0]  kind;
    logic [15:0] val;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   alu_pulses;

`ifdef PC_SEQUENCER_INSTR_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_flags"}, {24'd0, MemRead, AluStart, PcStep, PcLoad, PcOffsetEnable, Busy, Halted, Error}, 32'd0);
    chk({tag, "_ir"}, {16'd0, IrOut}, 32'd0);
    chk({tag, "_vals"}, {7'd0, PcLoadValue, PcOffset}, 32'd0);
    chk({tag, "_count"}, {16'd0, InstrCount}, 32'd0);
  endtask

  task automatic push_exp(input logic [15:0] ins);
    exp_t e;
    e.val = 16'd0;
    case (ins[15:12])
      4'h0: e.kind = 3'd0;
      4'hC: begin e.kind = 3'd1; e.val = {4'h0, ins[11:0]}; end
      4'hD: begin
        if (ZeroFlag) begin e.kind = 3'd2; e.val = {7'd0, ins[8:0]}; end
        else e.kind = 3'd0;
      end
      4'hF: e.kind = 3'd3;
      default: e.kind = 3'd0;
    endcase
    sb.push_back(e);
  endtask

  // Called while in FETCH; returns in DECODE with the instruction latched.
  task automatic fetch_instr(input logic [15:0] ins, input bit push);
    chk("fetch_memread", {31'd0, MemRead}, 32'd1);
    MemReady = 1'b1;
    Instr    = ins;
    if (push) push_exp(ins);
    tick();
    MemReady = 1'b0;
    Instr    = 16'hA5A5;
    #1;
    chk("decode_ir", {16'd0, IrOut}, {16'd0, ins});
    chk("decode_memread", {31'd0, MemRead}, 32'd0);
  endtask

  task automatic wait_pc(input string tag);
    exp_t a;
    exp_t e;
    bit   found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (PcStep || PcLoad || PcOffsetEnable || Halted) found = 1'b1;
      else tick();
    end
    a.kind = !found ? 3'd7 : PcLoad ? 3'd1 : PcOffsetEnable ? 3'd2 : PcStep ? 3'd0 : 3'd3;
    a.val  = PcLoad ? PcLoadValue : PcOffsetEnable ? {7'd0, PcOffset} : 16'd0;
    chk({tag, "_onehot"}, {31'd0, (32'(PcStep) + 32'(PcLoad) + 32'(PcOffsetEnable)) <= 1}, 32'd1);
    chk({tag, "_ldval_idle"}, {16'd0, PcLoad ? 16'd0 : PcLoadValue}, 32'd0);
    chk({tag, "_offs_idle"}, {23'd0, PcOffsetEnable ? 9'd0 : PcOffset}, 32'd0);
    chk({tag, "_sb_size"}, sb.size(), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_kind"}, {29'd0, a.kind}, {29'd0, e.kind});
      chk({tag, "_val"}, {16'd0, a.val}, {16'd0, e.val});
    end
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    #2;
    Reset = 1'b0;
  endtask

  initial begin
    Reset = 1'b1; Start = 1'b0; MemReady = 1'b0; Instr = 16'd0;
    ZeroFlag = 1'b0; AluDone = 1'b0;
    repeat (3) tick();
    chk_all_zero("reset");
    Reset = 1'b0;
    repeat (2) tick();
    chk("idle_without_start", {31'd0, Busy}, 32'd0);
    Start = 1'b1;
    tick();
    Start = 1'b0;
    chk("start_busy", {31'd0, Busy}, 32'd1);

    fetch_instr(16'h0000, 1'b1);
    wait_pc("nop");
    tick();
    chk("nop_back_fetch", {31'd0, MemRead}, 32'd1);

    fetch_instr(16'hC123, 1'b1);
    chk("jmp_no_step", {31'd0, PcStep}, 32'd0);
    wait_pc("jmp");
    tick();
    chk("jmp_single", {30'd0, PcLoad, PcStep}, 32'd0);

    ZeroFlag = 1'b1;
    fetch_instr(16'hD005, 1'b1);
    wait_pc("bz_taken");
    tick();
    ZeroFlag = 1'b0;
    fetch_instr(16'hD005, 1'b1);
    wait_pc("bz_not_taken");
    tick();

    fetch_instr(16'h3000, 1'b1);
    alu_pulses = 32'(AluStart);
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("alu_wait_busy", {31'd0, Busy}, 32'd1);
      chk("alu_wait_nostep", {31'd0, PcStep}, 32'd0);
      alu_pulses += 32'(AluStart);
      tick();
    end
    AluDone = 1'b1;
    #1;
    wait_pc("alu");
    chk("alu_pulses", alu_pulses, 32'd1);
    tick();
    AluDone = 1'b0;
    chk("alu_back_fetch", {31'd0, MemRead}, 32'd1);
    chk("count_after_5", {16'd0, InstrCount}, CNT_EN ? 32'd5 : 32'd0);

    fetch_instr(16'hF000, 1'b1);
    wait_pc("halt");
    Start = 1'b1;
    repeat (3) tick();
    Start = 1'b0;
    chk("halt_sticky", {29'd0, Halted, Busy, MemRead}, 32'd4);
    chk("count_after_halt", {16'd0, InstrCount}, CNT_EN ? 32'd6 : 32'd0);

    do_reset();
    Start = 1'b1;
    tick();
    Start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("timeout_fetching", {30'd0, MemRead, Error}, 32'd2);
      tick();
    end
    chk("timeout_error", {30'd0, Error, Busy}, 32'd2);
    Start = 1'b1;
    repeat (2) tick();
    Start = 1'b0;
    chk("error_sticky", {30'd0, Error, MemRead}, 32'd2);

    do_reset();
    Start = 1'b1;
    tick();
    Start = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    fetch_instr(16'h0000, 1'b1);
    chk("late_ready_no_error", {30'd0, Error, Busy}, 32'd1);
    wait_pc("late_nop");
    tick();

    fetch_instr(16'h3000, 1'b0);
    tick();
    chk("mid_alu_busy", {31'd0, Busy}, 32'd1);
    Reset = 1'b1;
    AluDone = 1'b1;
    #1;
    chk_all_zero("async_reset");
    tick();
    chk_all_zero("held_reset");
    Reset = 1'b0;
    AluDone = 1'b0;
    repeat (3) tick();
    chk("post_reset_idle", {30'd0, Busy, MemRead}, 32'd0);

    Start = 1'b1;
    tick();
    Start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      fetch_instr(16'h0000, 1'b1);
      wait_pc("count_nop");
      tick();
    end
    chk("count_three", {16'd0, InstrCount}, CNT_EN ? 32'd3 : 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
